wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 150 +++++++++++++++
 tb/tb_wb_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the integer pipeline.
//
// Accepts one entry at a time from the MEM stage. A non-load commits on the
// cycle after it is accepted. A load waits for mem_rvalid, extracts and
// extends the addressed lane from the raw beat, and commits on the following
// cycle. Commits may run back to back because a new entry can be accepted
// during COMMIT.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_*                  MEM-stage entry (valid/ready handshake)
//   mem_rvalid, mem_rdata load data return (aligned XLEN-bit beat)
//   wr_en/addr/data       register-file write port
//   pc_wb                 committed pc for diff-test, 0 when not committing
//   fwd_valid/rd/data     bypass of the held entry to decode
//   retire_cnt            committed-instruction counter (wraps)
//
// Lane extraction assumes XLEN is at least 64.
module wb_stage #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_rd_wen,
   input  logic [XLEN-1:0]   in_result,
   input  logic              in_is_load,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_unsigned,
   input  logic [2:0]        in_ld_addr_lo,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              wr_en,
   output logic [REG_AW-1:0] wr_addr,
   output logic [XLEN-1:0]   wr_data,
   output logic [XLEN-1:0]   pc_wb,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [XLEN-1:0]   fwd_data,
   output logic [63:0]       retire_cnt
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StWaitMem = 2'd1;
   localparam logic [1:0] StCommit  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [XLEN-1:0]   pc_q;
   logic [REG_AW-1:0] rd_q;
   logic              rd_wen_q;
   logic [XLEN-1:0]   data_q;
   logic [1:0]        ld_size_q;
   logic              ld_unsigned_q;
   logic [2:0]        ld_addr_lo_q;
   logic [63:0]       retire_q;

   logic              accept;
   logic              writes_rd;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_word;
   logic              sext;
   logic [XLEN-1:0]   ld_ext;

   assign in_ready  = (state_q != StWaitMem);
   assign accept    = in_valid && in_ready;
   assign writes_rd = rd_wen_q && (rd_q != '0);

   // Lane select; address bits below the access size are ignored.
   assign ld_byte = mem_rdata[{ld_addr_lo_q, 3'b000} +: 8];
   assign ld_half = mem_rdata[{ld_addr_lo_q[2:1], 4'b0000} +: 16];
   assign ld_word = mem_rdata[{ld_addr_lo_q[2], 5'b00000} +: 32];
   assign sext    = !ld_unsigned_q;

   always_comb begin
      ld_ext = '0;
      unique case (ld_size_q)
         2'd0:    ld_ext = {{(XLEN-8){sext & ld_byte[7]}}, ld_byte};
         2'd1:    ld_ext = {{(XLEN-16){sext & ld_half[15]}}, ld_half};
         2'd2:    ld_ext = {{(XLEN-32){sext & ld_word[31]}}, ld_word};
         2'd3:    ld_ext = mem_rdata;
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StCommit: begin
            if (accept) begin
               state_d = in_is_load ? StWaitMem : StCommit;
            end else begin
               state_d = StIdle;
            end
         end
         StWaitMem: begin
            if (mem_rvalid) begin
               state_d = StCommit;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         pc_q          <= '0;
         rd_q          <= '0;
         rd_wen_q      <= 1'b0;
         data_q        <= '0;
         ld_size_q     <= 2'd0;
         ld_unsigned_q <= 1'b0;
         ld_addr_lo_q  <= 3'd0;
         retire_q      <= 64'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pc_q          <= in_pc;
            rd_q          <= in_rd;
            rd_wen_q      <= in_rd_wen;
            data_q        <= in_result;
            ld_size_q     <= in_ld_size;
            ld_unsigned_q <= in_ld_unsigned;
            ld_addr_lo_q  <= in_ld_addr_lo;
         end else if ((state_q == StWaitMem) && mem_rvalid) begin
            data_q <= ld_ext;
         end
         if (state_q == StCommit) begin
            retire_q <= retire_q + 64'd1;
         end
      end
   end

   // Visible effects are masked while rst is high so a held entry is dropped
   // without a regfile write even in the cycle reset is raised.
   assign wr_en      = (state_q == StCommit) && writes_rd && !rst;
   assign wr_addr    = rd_q;
   assign wr_data    = data_q;
   assign pc_wb      = ((state_q == StCommit) && !rst) ? pc_q : '0;
   assign fwd_valid  = (state_q != StIdle) && writes_rd && !rst;
   assign fwd_rd     = rd_q;
   assign fwd_data   = data_q;
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic [63:0] in_result;
   logic        in_is_load;
   logic [1:0]  in_ld_size;
   logic        in_ld_unsigned;
   logic [2:0]  in_ld_addr_lo;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [63:0] pc_wb;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [63:0] fwd_data;
   logic [63:0] retire_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] exp_cnt;
   logic [63:0] e_pc;
   logic [63:0] e_data;
   logic [4:0]  e_rd;
   logic        e_wen;

   wb_stage #(
      .XLEN  (64),
      .REG_AW(5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_rd         (in_rd),
      .in_rd_wen     (in_rd_wen),
      .in_result     (in_result),
      .in_is_load    (in_is_load),
      .in_ld_size    (in_ld_size),
      .in_ld_unsigned(in_ld_unsigned),
      .in_ld_addr_lo (in_ld_addr_lo),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .pc_wb         (pc_wb),
      .fwd_valid     (fwd_valid),
      .fwd_rd        (fwd_rd),
      .fwd_data      (fwd_data),
      .retire_cnt    (retire_cnt)
   );

   always #5 clk = ~clk;

   // Load result from size/sign rules using byte arithmetic.
   function automatic logic [63:0] ref_load(input logic [63:0] beat, input int sz,
                                            input bit uns, input int lo);
      int          nb;
      int          off;
      logic [63:0] v;
      logic [63:0] mask;
      nb  = 1 << sz;
      off = (lo / nb) * nb;
      v   = beat >> (off * 8);
      if (sz < 3) begin
         mask = (64'd1 << (nb * 8)) - 64'd1;
         v    = v & mask;
         if (!uns && v[nb*8-1]) v = v | ~mask;
      end
      return v;
   endfunction

   function automatic logic e_fwd();
      return e_wen && (e_rd != 5'd0);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scramble_inputs();
      in_pc          = rnd64();
      in_rd          = 5'($urandom());
      in_rd_wen      = 1'($urandom());
      in_result      = rnd64();
      in_is_load     = 1'($urandom());
      in_ld_size     = 2'($urandom());
      in_ld_unsigned = 1'($urandom());
      in_ld_addr_lo  = 3'($urandom());
   endtask

   // Present an entry; mem_rvalid noise here must be ignored (not in WAIT_MEM).
   task automatic drive(input logic ld, input logic [63:0] pc, input logic [4:0] rd,
                        input logic wen, input logic [63:0] res, input logic [1:0] sz,
                        input logic uns, input logic [2:0] lo);
      in_valid       = 1'b1;
      in_is_load     = ld;
      in_pc          = pc;
      in_rd          = rd;
      in_rd_wen      = wen;
      in_result      = res;
      in_ld_size     = sz;
      in_ld_unsigned = uns;
      in_ld_addr_lo  = lo;
      mem_rvalid     = 1'($urandom_range(0, 1));
      mem_rdata      = rnd64();
      e_pc           = pc;
      e_rd           = rd;
      e_wen          = wen;
      if (!ld) e_data = res;
   endtask

   task automatic check_commit(input string tag);
      check({tag, ".wr_en"}, 64'(wr_en), 64'(e_fwd()));
      if (e_fwd()) check({tag, ".wr_addr"}, 64'(wr_addr), 64'(e_rd));
      check({tag, ".wr_data"}, wr_data, e_data);
      check({tag, ".pc_wb"}, pc_wb, e_pc);
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(e_fwd()));
      if (e_fwd()) begin
         check({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(e_rd));
         check({tag, ".fwd_data"}, fwd_data, e_data);
      end
      check({tag, ".retire_cnt"}, retire_cnt, exp_cnt);
      exp_cnt = exp_cnt + 64'd1;
   endtask

   // Ends in the commit cycle with in_valid low; caller may issue the next entry.
   task automatic alu_txn(input string tag, input logic [63:0] pc, input logic [4:0] rd,
                          input logic wen, input logic [63:0] res);
      drive(1'b0, pc, rd, wen, res, 2'($urandom()), 1'($urandom()), 3'($urandom()));
      tick();
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      scramble_inputs();
      check_commit(tag);
   endtask

   task automatic load_txn(input string tag, input logic [63:0] pc, input logic [4:0] rd,
                           input logic wen, input logic [1:0] sz, input logic uns,
                           input logic [2:0] lo, input logic [63:0] beat, input int waitn);
      drive(1'b1, pc, rd, wen, rnd64(), sz, uns, lo);
      e_data = ref_load(beat, int'(sz), uns, int'(lo));
      tick();
      for (int i = 0; i < waitn; i++) begin
         scramble_inputs();
         in_valid   = 1'($urandom()); // must not be accepted while waiting
         mem_rvalid = 1'b0;
         mem_rdata  = rnd64();
         check({tag, ".wait.in_ready"}, 64'(in_ready), 64'd0);
         check({tag, ".wait.wr_en"}, 64'(wr_en), 64'd0);
         check({tag, ".wait.pc_wb"}, pc_wb, 64'd0);
         check({tag, ".wait.fwd_valid"}, 64'(fwd_valid), 64'(e_fwd()));
         tick();
      end
      check({tag, ".rv.in_ready"}, 64'(in_ready), 64'd0);
      in_valid   = 1'($urandom());
      mem_rvalid = 1'b1;
      mem_rdata  = beat;
      tick();
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = rnd64();
      check_commit(tag);
   endtask

   task automatic idle_check(input string tag);
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      tick();
      check({tag, ".wr_en"}, 64'(wr_en), 64'd0);
      check({tag, ".pc_wb"}, pc_wb, 64'd0);
      check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'd0);
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      check({tag, ".retire_cnt"}, retire_cnt, exp_cnt);
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      scramble_inputs();
      exp_cnt    = 64'd0;
      tick();
      tick();
      check("rst.wr_en", 64'(wr_en), 64'd0);
      check("rst.pc_wb", pc_wb, 64'd0);
      check("rst.fwd_valid", 64'(fwd_valid), 64'd0);
      check("rst.retire_cnt", retire_cnt, 64'd0);
      rst = 1'b0;
      tick();
      check("post_rst.in_ready", 64'(in_ready), 64'd1);

      // Single ALU op, commit on the next cycle.
      alu_txn("alu", 64'h8000_0000, 5'd5, 1'b1, 64'h1234);
      check("alu.const", wr_data, 64'h1234);
      idle_check("alu.after");

      // Loads with fixed lanes, issued back to back.
      load_txn("lb", 64'h8000_0004, 5'd3, 1'b1, 2'd0, 1'b0, 3'd6,
               64'h0080_0000_0000_0000, 3);
      check("lb.const", wr_data, 64'hFFFF_FFFF_FFFF_FF80);
      load_txn("lwu", 64'h8000_0008, 5'd7, 1'b1, 2'd2, 1'b1, 3'd4,
               64'hDEAD_BEEF_0000_0000, 1);
      check("lwu.const", wr_data, 64'h0000_0000_DEAD_BEEF);
      load_txn("lh", 64'h8000_000C, 5'd9, 1'b1, 2'd1, 1'b0, 3'd2,
               64'h0000_0000_8001_0000, 0);
      check("lh.const", wr_data, 64'hFFFF_FFFF_FFFF_8001);
      idle_check("loads.after");

      // rd = x0 commits and counts but never writes or forwards.
      alu_txn("rd0", 64'h8000_0100, 5'd0, 1'b1, 64'hAAAA);
      idle_check("rd0.after");

      // Three back-to-back non-loads.
      alu_txn("b2b0", 64'h8000_0200, 5'd1, 1'b1, 64'h11);
      alu_txn("b2b1", 64'h8000_0204, 5'd2, 1'b1, 64'h22);
      alu_txn("b2b2", 64'h8000_0208, 5'd3, 1'b0, 64'h33);
      idle_check("b2b.after");

      // mem_rvalid in IDLE has no effect.
      mem_rvalid = 1'b1;
      mem_rdata  = rnd64();
      tick();
      mem_rvalid = 1'b0;
      check("idle_rv.wr_en", 64'(wr_en), 64'd0);
      check("idle_rv.in_ready", 64'(in_ready), 64'd1);
      check("idle_rv.retire_cnt", retire_cnt, exp_cnt);

      // Random mix against the reference model.
      for (int n = 0; n < 80; n++) begin
         logic [4:0] rd;
         rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         if ($urandom_range(0, 3) == 0) idle_check("rnd.idle");
         if ($urandom_range(0, 1) == 1) begin
            load_txn("rnd.ld", rnd64(), rd, 1'($urandom()), 2'($urandom()), 1'($urandom()),
                     3'($urandom()), rnd64(), int'($urandom_range(0, 3)));
         end else begin
            alu_txn("rnd.alu", rnd64(), rd, 1'($urandom()), rnd64());
         end
      end
      idle_check("rnd.after");

      // Reset raised in COMMIT drops the commit.
      alu_txn("rstc", 64'h8000_0300, 5'd4, 1'b1, 64'h55);
      rst = 1'b1;
      #1;
      check("rstc.wr_en", 64'(wr_en), 64'd0);
      check("rstc.pc_wb", pc_wb, 64'd0);
      tick();
      rst     = 1'b0;
      exp_cnt = 64'd0;
      check("rstc.retire_cnt", retire_cnt, 64'd0);
      check("rstc.in_ready", 64'(in_ready), 64'd1);

      // Reset in WAIT_MEM, then late mem_rvalid must not commit.
      drive(1'b1, 64'h8000_0400, 5'd6, 1'b1, 64'h0, 2'd3, 1'b0, 3'd0);
      tick();
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      tick();
      check("rstw.in_ready_wait", 64'(in_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = rnd64();
      tick();
      mem_rvalid = 1'b0;
      check("rstw.wr_en", 64'(wr_en), 64'd0);
      check("rstw.pc_wb", pc_wb, 64'd0);
      check("rstw.in_ready", 64'(in_ready), 64'd1);
      check("rstw.retire_cnt", retire_cnt, 64'd0);
      idle_check("rstw.after");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
